// File: rtl/gray_pkg.sv
// Shared Gray-code helpers, FSM encoding and widths for the Gray producer/consumer pair.
// Helpers work on GRAY_MAX_W-bit vectors; narrower callers zero-extend and truncate.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;
    localparam int ERR_CNT_W  = 8;

    localparam logic [0:0] S_PRIME = 1'b0;
    localparam logic [0:0] S_TRACK = 1'b1;

    // Upper zero bits of a zero-extended code do not disturb the low binary bits.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_sync_decoder_if.sv
// Bus between a free-running Gray producer (master) and the synchronising decoder (slave).
interface gray_sync_decoder_if
    import gray_pkg::*;
#(
    parameter int N = 4
);
    logic [N-1:0]           gray_in;
    logic [N-1:0]           bin_out;
    logic                   bin_valid;
    logic [N-1:0]           step;
    logic                   step_valid;
    logic                   err;
    logic                   err_sticky;
    logic [ERR_CNT_W-1:0]   err_cnt;

    modport master (
        output gray_in,
        input  bin_out, bin_valid, step, step_valid, err, err_sticky, err_cnt
    );

    modport slave (
        input  gray_in,
        output bin_out, bin_valid, step, step_valid, err, err_sticky, err_cnt
    );
endinterface

// File: rtl/gray_sync_chain.sv
// Plain N-bit synchroniser flop chain, SYNC_STAGES deep, reused at other CDC points.
module gray_sync_chain #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] r_stages [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stages[i] <= '0;
            end
        end else begin
            r_stages[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign q = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronises a foreign-domain Gray count, decodes it to binary, reports per-cycle step and flags multi-bit jumps.
// Optional saturating error counter enabled by defining GRAY_SYNC_ERR_CNT_EN. N <= 32, SYNC_STAGES in 2..4.
module gray_sync_decoder
    import gray_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    gray_sync_decoder_if.slave bus
);

    localparam logic [2:0] FILL_LAST = 3'(SYNC_STAGES);

    logic [N-1:0] w_syncG;
    logic [N-1:0] w_syncBin;
    logic [N-1:0] w_prevBin;
    logic         w_illegal;

    logic [0:0]   r_state;
    logic [2:0]   r_fillCnt;
    logic [N-1:0] r_prevGray;
    logic [N-1:0] r_binOut;
    logic         r_binValid;
    logic [N-1:0] r_step;
    logic         r_stepValid;
    logic         r_err;
    logic         r_errSticky;

    gray_sync_chain #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_chain (
        .clk (clk),
        .rst (rst),
        .d   (bus.gray_in),
        .q   (w_syncG)
    );

    assign w_syncBin = N'(gray2bin(GRAY_MAX_W'(w_syncG)));
    assign w_prevBin = N'(gray2bin(GRAY_MAX_W'(r_prevGray)));
    assign w_illegal = popcount(GRAY_MAX_W'(w_syncG ^ r_prevGray)) > 6'd1;

    // Priming waits until the chain holds post-reset samples, so the reset zeros never look like a jump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PRIME;
            r_fillCnt   <= '0;
            r_prevGray  <= '0;
            r_binOut    <= '0;
            r_binValid  <= 1'b0;
            r_step      <= '0;
            r_stepValid <= 1'b0;
            r_err       <= 1'b0;
            r_errSticky <= 1'b0;
        end else begin
            case (r_state)
                S_PRIME: begin
                    if (r_fillCnt == FILL_LAST) begin
                        r_prevGray <= w_syncG;
                        r_binOut   <= w_syncBin;
                        r_binValid <= 1'b1;
                        r_state    <= S_TRACK;
                    end else begin
                        r_fillCnt <= r_fillCnt + 3'd1;
                    end
                end
                S_TRACK: begin
                    r_prevGray <= w_syncG;
                    r_binOut   <= w_syncBin;
                    if (w_illegal) begin
                        r_err       <= 1'b1;
                        r_errSticky <= 1'b1;
                        r_step      <= '0;
                        r_stepValid <= 1'b0;
                    end else begin
                        r_err       <= 1'b0;
                        r_step      <= w_syncBin - w_prevBin;
                        r_stepValid <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef GRAY_SYNC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_errCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errCnt <= '0;
        end else if (r_state == S_TRACK && w_illegal && r_errCnt != '1) begin
            r_errCnt <= r_errCnt + ERR_CNT_W'(1);
        end
    end

    assign bus.err_cnt = r_errCnt;
`else
    assign bus.err_cnt = '0;
`endif

    assign bus.bin_out    = r_binOut;
    assign bus.bin_valid  = r_binValid;
    assign bus.step       = r_step;
    assign bus.step_valid = r_stepValid;
    assign bus.err        = r_err;
    assign bus.err_sticky = r_errSticky;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Bench for gray_sync_decoder: hand-derived vector table delayed through a scoreboard queue, plus reset/saturation sequences.
module tb_gray_sync_decoder;

    localparam int LAT = 3;
`ifdef GRAY_SYNC_ERR_CNT_EN
    localparam logic [7:0] CNT1   = 8'd1;
    localparam logic [7:0] CNTSAT = 8'd255;
`else
    localparam logic [7:0] CNT1   = 8'd0;
    localparam logic [7:0] CNTSAT = 8'd0;
`endif

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic [3:0] step;
        logic       sv;
        logic       err;
        logic       sticky;
        logic [7:0] cnt;
    } vecT;

    typedef struct {
        vecT v;
        int  idx;
        int  due;
    } pendT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    vecT  vecs [21];
    pendT sb [$];

    gray_sync_decoder_if #(.N(4)) bus ();

    gray_sync_decoder #(.N(4), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vecT mk(input logic [3:0] g, input logic [3:0] b, input logic [3:0] s,
                               input logic sv, input logic e, input logic st, input logic [7:0] c);
        vecT v;
        v.gray = g; v.bin = b; v.step = s; v.sv = sv; v.err = e; v.sticky = st; v.cnt = c;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] g);
        bus.gray_in = g;
    endtask

    task automatic serviceScoreboard();
        pendT p;
        while (sb.size() > 0 && sb[0].due <= cycle) begin
            p = sb.pop_front();
            checkOutput($sformatf("row%0d due", p.idx), 32'(p.due), 32'(cycle));
            checkOutput($sformatf("row%0d bin_out", p.idx), 32'(bus.bin_out), 32'(p.v.bin));
            checkOutput($sformatf("row%0d bin_valid", p.idx), 32'(bus.bin_valid), 32'd1);
            checkOutput($sformatf("row%0d step", p.idx), 32'(bus.step), 32'(p.v.step));
            checkOutput($sformatf("row%0d step_valid", p.idx), 32'(bus.step_valid), 32'(p.v.sv));
            checkOutput($sformatf("row%0d err", p.idx), 32'(bus.err), 32'(p.v.err));
            checkOutput($sformatf("row%0d err_sticky", p.idx), 32'(bus.err_sticky), 32'(p.v.sticky));
            checkOutput($sformatf("row%0d err_cnt", p.idx), 32'(bus.err_cnt), 32'(p.v.cnt));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle++;
        serviceScoreboard();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " bin_out"}, 32'(bus.bin_out), 32'd0);
        checkOutput({tag, " bin_valid"}, 32'(bus.bin_valid), 32'd0);
        checkOutput({tag, " step"}, 32'(bus.step), 32'd0);
        checkOutput({tag, " step_valid"}, 32'(bus.step_valid), 32'd0);
        checkOutput({tag, " err"}, 32'(bus.err), 32'd0);
        checkOutput({tag, " err_sticky"}, 32'(bus.err_sticky), 32'd0);
        checkOutput({tag, " err_cnt"}, 32'(bus.err_cnt), 32'd0);
    endtask

    initial begin
        pendT p;

        // Stream continues from a primed value of Gray 0110 (bin 4).
        vecs[0]  = mk(4'b0111, 4'd5,  4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[1]  = mk(4'b0101, 4'd6,  4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[2]  = mk(4'b0100, 4'd7,  4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[3]  = mk(4'b1100, 4'd8,  4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[4]  = mk(4'b1101, 4'd9,  4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[5]  = mk(4'b1111, 4'd10, 4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[6]  = mk(4'b1110, 4'd11, 4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[7]  = mk(4'b1010, 4'd12, 4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[8]  = mk(4'b1011, 4'd13, 4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[9]  = mk(4'b1001, 4'd14, 4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[10] = mk(4'b1000, 4'd15, 4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[11] = mk(4'b0000, 4'd0,  4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[12] = mk(4'b0001, 4'd1,  4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[13] = mk(4'b0011, 4'd2,  4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[14] = mk(4'b0010, 4'd3,  4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[15] = mk(4'b0011, 4'd2,  4'd15, 1'b1, 1'b0, 1'b0, 8'd0);
        vecs[16] = mk(4'b0001, 4'd1,  4'd15, 1'b1, 1'b0, 1'b0, 8'd0);
        vecs[17] = mk(4'b0001, 4'd1,  4'd0,  1'b1, 1'b0, 1'b0, 8'd0);
        vecs[18] = mk(4'b0110, 4'd4,  4'd0,  1'b0, 1'b1, 1'b1, CNT1);
        vecs[19] = mk(4'b0110, 4'd4,  4'd0,  1'b1, 1'b0, 1'b1, CNT1);
        vecs[20] = mk(4'b0111, 4'd5,  4'd1,  1'b1, 1'b0, 1'b1, CNT1);

        applyStimulus(4'b0110);
        repeat (3) tick();
        checkAllZero("reset");

        rst = 1'b0;
        tick();
        checkOutput("prime fill1 bin_valid", 32'(bus.bin_valid), 32'd0);
        tick();
        checkOutput("prime fill2 bin_valid", 32'(bus.bin_valid), 32'd0);
        tick();
        checkOutput("prime bin_out", 32'(bus.bin_out), 32'd4);
        checkOutput("prime bin_valid", 32'(bus.bin_valid), 32'd1);
        checkOutput("prime step_valid", 32'(bus.step_valid), 32'd0);
        checkOutput("prime err", 32'(bus.err), 32'd0);
        tick();
        checkOutput("track1 step_valid", 32'(bus.step_valid), 32'd1);
        checkOutput("track1 step", 32'(bus.step), 32'd0);
        checkOutput("track1 err", 32'(bus.err), 32'd0);

        for (int i = 0; i < 21; i++) begin
            tick();
            applyStimulus(vecs[i].gray);
            p.v = vecs[i];
            p.idx = i;
            p.due = cycle + LAT;
            sb.push_back(p);
        end
        repeat (LAT + 1) tick();
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("[TB] driving 300 illegal jumps");
        for (int i = 0; i < 300; i++) begin
            tick();
            applyStimulus((i % 2 == 1) ? 4'b0110 : 4'b0000);
        end
        repeat (LAT) tick();
        checkOutput("sat last err", 32'(bus.err), 32'd1);
        tick();
        checkOutput("sat settle err", 32'(bus.err), 32'd0);
        checkOutput("sat settle step_valid", 32'(bus.step_valid), 32'd1);
        checkOutput("sat settle bin_out", 32'(bus.bin_out), 32'd4);
        checkOutput("sat err_sticky", 32'(bus.err_sticky), 32'd1);
        checkOutput("sat err_cnt", 32'(bus.err_cnt), 32'(CNTSAT));

        tick();
        applyStimulus(4'b0111);
        tick();
        applyStimulus(4'b0101);
        tick();
        #2 rst = 1'b1;
        #1 checkAllZero("midreset");
        tick();
        applyStimulus(4'b0010);
        rst = 1'b0;
        tick();
        checkOutput("reprime fill1 bin_valid", 32'(bus.bin_valid), 32'd0);
        checkOutput("reprime fill1 err", 32'(bus.err), 32'd0);
        tick();
        checkOutput("reprime fill2 bin_valid", 32'(bus.bin_valid), 32'd0);
        tick();
        checkOutput("reprime bin_out", 32'(bus.bin_out), 32'd3);
        checkOutput("reprime bin_valid", 32'(bus.bin_valid), 32'd1);
        checkOutput("reprime err", 32'(bus.err), 32'd0);
        checkOutput("reprime err_sticky", 32'(bus.err_sticky), 32'd0);
        tick();
        checkOutput("retrack step_valid", 32'(bus.step_valid), 32'd1);
        checkOutput("retrack step", 32'(bus.step), 32'd0);
        checkOutput("retrack err", 32'(bus.err), 32'd0);
        checkOutput("retrack err_cnt", 32'(bus.err_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
